arb8_rr_dec: RTL and testbench

Round-robin arbiter sharing one resource among eight requesters. Each grant is a 3-bit index, and the block expands that index into a one-hot grant vector through a 3-to-8 decoder. The arbiter picks one winner at a time and holds the grant until the winner releases it, with optional timeout preemption. It sits between eight client request lines and the shared resource's select/enable inputs.

---
 rtl/arb8_pkg.sv | 30 +++
 rtl/dec3to8.sv | 14 +
 rtl/arb8_rr_dec.sv | 108 ++++++++++
 tb/tb_arb8_rr_dec.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/arb8_pkg.sv
// Shared types and the round-robin search for the eight-way arbiter.
package arb8_pkg;

  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 3;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  // First set request after 'last', wrapping; the 3-bit add wraps modulo 8.
  function automatic logic [IDX_W-1:0] next_rr(input logic [NUM_REQ-1:0] req,
                                               input logic [IDX_W-1:0]   last);
    logic [IDX_W-1:0] win;
    logic [IDX_W-1:0] cand;
    logic             found;
    win   = last;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = last + IDX_W'(i);
      if (!found && req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/dec3to8.sv
// Combinational 3-to-8 one-hot decoder.
module dec3to8
  import arb8_pkg::*;
(
  input  logic [IDX_W-1:0]   a,
  output logic [NUM_REQ-1:0] dout
);

  always_comb begin
    dout    = '0;
    dout[a] = 1'b1;
  end

endmodule

// File: rtl/arb8_rr_dec.sv
// Eight-way round-robin arbiter with one-hot grant decode.
// Define ARB_TIMEOUT_EN to add hold-time preemption limited by MAX_HOLD.
module arb8_rr_dec
  import arb8_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_vld,
  output logic               timeout
);

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("arb8_rr_dec: MAX_HOLD must be in 1..255");
  end

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic [IDX_W-1:0] win;
  logic [NUM_REQ-1:0] dec_out;

`ifdef ARB_TIMEOUT_EN
  localparam int               CNT_W  = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(MAX_HOLD - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
`endif

  assign win = next_rr(req, last_q);

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    gnt_idx_d = gnt_idx_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (req != '0) begin
          state_d   = ARB_BUSY;
          last_d    = win;
          gnt_idx_d = win;
`ifdef ARB_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end
      end
      ARB_BUSY: begin
        // Release is checked first so it beats a coincident terminal count.
        if (!req[gnt_idx_q]) begin
          state_d = ARB_IDLE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_q == CNT_TC) begin
          state_d   = ARB_IDLE;
          timeout_d = 1'b1;
        end else begin
          cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ARB_IDLE;
      last_q    <= IDX_W'(NUM_REQ - 1);
      gnt_idx_q <= '0;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      gnt_idx_q <= gnt_idx_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  dec3to8 u_dec (
    .a    (gnt_idx_q),
    .dout (dec_out)
  );

  assign gnt_vld = (state_q == ARB_BUSY);
  assign gnt_idx = gnt_idx_q;
  assign gnt     = dec_out & {NUM_REQ{gnt_vld}};

`ifdef ARB_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_arb8_rr_dec.sv
// Directed bench for arb8_rr_dec with a cycle model feeding an expectation queue.
module tb_arb8_rr_dec;

  localparam int MAX_HOLD = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_vld;
  logic       timeout;

  arb8_rr_dec #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       vld;
    logic       to;
  } exp_t;

  exp_t  sb[$];
  int    n_assert = 0;
  int    n_fail   = 0;
  string phase    = "init";

  int m_owner;
  int m_last;
  int m_cnt;
  bit m_to;

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s/%s: observed %0h expected %0h", phase, tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_owner = -1;
    m_last  = 7;
    m_cnt   = 0;
    m_to    = 1'b0;
    sb.delete();
  endfunction

  function automatic void model_advance(input logic [7:0] r);
    int c;
    m_to = 1'b0;
    if (m_owner < 0) begin
      if (r != 8'h00) begin
        for (int k = 1; k <= 8; k++) begin
          c = (m_last + k) % 8;
          if (r[c]) begin
            m_owner = c;
            m_last  = c;
            m_cnt   = 0;
            break;
          end
        end
      end
    end else if (!r[m_owner]) begin
      m_owner = -1;
    end else if (TO_EN && m_cnt == MAX_HOLD - 1) begin
      m_owner = -1;
      m_to    = 1'b1;
    end else begin
      m_cnt++;
    end
  endfunction

  task automatic step(input logic [7:0] r);
    exp_t e;
    req = r;
    model_advance(r);
    e.vld = (m_owner >= 0);
    e.gnt = (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00;
    e.idx = (m_owner >= 0) ? 3'(m_owner) : 3'd0;
    e.to  = m_to;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check8("gnt", gnt, e.gnt);
    check8("gnt_vld", {7'b0, gnt_vld}, {7'b0, e.vld});
    check8("timeout", {7'b0, timeout}, {7'b0, e.to});
    if (e.vld) check8("gnt_idx", {5'b0, gnt_idx}, {5'b0, e.idx});
  endtask

  task automatic do_reset();
    @(negedge clk);
    req = 8'h00;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check8("rst_gnt", gnt, 8'h00);
    check8("rst_vld", {7'b0, gnt_vld}, 8'h00);
    check8("rst_timeout", {7'b0, timeout}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    rst = 1'b1;
    req = 8'h00;
    model_reset();

    phase = "reset";
    do_reset();

    phase = "single";
    step(8'h01);
    check8("first_gnt", gnt, 8'h01);
    check8("first_idx", {5'b0, gnt_idx}, 8'h00);
    step(8'h00);
    check8("drop_gnt", gnt, 8'h00);
    step(8'h00);

    phase = "rotate";
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(8'hFF);
      check8("rot_winner", {5'b0, gnt_idx}, 8'(i % 8));
      step(8'hFF);
      step(8'hFF & ~(8'h01 << (i % 8)));
      check8("rot_bubble", {7'b0, gnt_vld}, 8'h00);
    end

    phase = "wrap";
    step(8'h20);
    check8("wrap_seed", {5'b0, gnt_idx}, 8'h05);
    step(8'h00);
    step(8'h25);
    check8("wrap_w0", {5'b0, gnt_idx}, 8'h00);
    step(8'h24);
    step(8'h25);
    check8("wrap_w2", {5'b0, gnt_idx}, 8'h02);
    step(8'h21);
    step(8'h25);
    check8("wrap_w5", {5'b0, gnt_idx}, 8'h05);
    step(8'h00);

    phase = "hold";
    do_reset();
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < 4; i++) step(8'h0C);
    step(8'h0C);
    check8("preempt_pulse", {7'b0, timeout}, 8'h01);
    check8("preempt_gnt", gnt, 8'h00);
    step(8'h0C);
    check8("preempt_next", gnt, 8'h08);
    step(8'h0C);
    check8("pulse_once", {7'b0, timeout}, 8'h00);
    step(8'h00);
`else
    for (int i = 0; i < 10; i++) step(8'h0C);
    check8("long_hold", gnt, 8'h04);
    step(8'h00);
`endif

    phase = "release_at_tc";
    do_reset();
    for (int i = 0; i < 4; i++) step(8'h04);
    step(8'h00);
    check8("no_pulse", {7'b0, timeout}, 8'h00);
    check8("released", {7'b0, gnt_vld}, 8'h00);
    step(8'h00);

    phase = "async_rst";
    do_reset();
    step(8'h10);
    check8("pre_rst_gnt", gnt, 8'h10);
    #2;
    rst = 1'b1;
    #1;
    check8("async_gnt", gnt, 8'h00);
    check8("async_vld", {7'b0, gnt_vld}, 8'h00);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(8'h11);
    check8("post_rst_winner", {5'b0, gnt_idx}, 8'h00);
    step(8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
